// File: rtl/batch_norm_pkg.sv
// Shared types and constants for the batch-normalisation pipeline.
package batch_norm_pkg;

  // Operating mode as seen on the mode port; 2'b11 is folded onto MODE_BN.
  typedef enum logic [1:0] {
    MODE_BYPASS  = 2'b00,
    MODE_BN      = 2'b01,
    MODE_BN_RELU = 2'b10,
    MODE_RSVD    = 2'b11
  } mode_e;

  localparam logic [31:0] FP_ONE  = 32'h3F80_0000;
  localparam logic [31:0] FP_ZERO = 32'h0000_0000;
  localparam logic [31:0] FP_QNAN = 32'h7FC0_0000;

  // Everything stage 2 needs about one sample (its channel travels separately
  // because the channel width depends on the table depth).
  typedef struct packed {
    logic [31:0] prod;   // A[c] * x
    logic [31:0] shift;  // B[c]
    logic [31:0] raw;    // x, for bypass
    mode_e       mode;
  } s1_payload_t;

  function automatic mode_e decode_mode(input logic [1:0] m);
    return (m == MODE_RSVD) ? MODE_BN : mode_e'(m);
  endfunction

endpackage

// File: rtl/bn_coef_table.sv
// Per-channel (A, B) coefficient register file: one write port, combinational
// read, resets to the identity transform (A=1.0, B=0.0).
module bn_coef_table
  import batch_norm_pkg::*;
#(
  parameter int NUM_CH = 16,
  parameter int CH_W   = $clog2(NUM_CH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            we,
  input  logic [CH_W-1:0] waddr,
  input  logic [31:0]     wdata_a,
  input  logic [31:0]     wdata_b,
  input  logic [CH_W-1:0] raddr,
  output logic [31:0]     rdata_a,
  output logic [31:0]     rdata_b
);

  logic [31:0] coef_a_q [NUM_CH];
  logic [31:0] coef_a_d [NUM_CH];
  logic [31:0] coef_b_q [NUM_CH];
  logic [31:0] coef_b_d [NUM_CH];

  // Apply a write to an in-range channel; out-of-range addresses are dropped.
  always_comb begin
    coef_a_d = coef_a_q;
    coef_b_d = coef_b_q;
    if (we && (int'(waddr) < NUM_CH)) begin
      coef_a_d[waddr] = wdata_a;
      coef_b_d[waddr] = wdata_b;
    end
  end

  // Table storage with identity reset.
  always_ff @(posedge clk) begin
    // NOTE: this table is reset entry by entry because reset must restore the
    // identity transform; a bulk RAM could not be cleared like this.
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        // NOTE: clocked state uses non-blocking '<=' so every flop samples
        // pre-edge values regardless of statement order.
        coef_a_q[i] <= FP_ONE;
        coef_b_q[i] <= FP_ZERO;
      end
    end else begin
      coef_a_q <= coef_a_d;
      coef_b_q <= coef_b_d;
    end
  end

  // Writes land at the edge, so a same-cycle reader sees the old pair.
  assign rdata_a = coef_a_q[raddr];
  assign rdata_b = coef_b_q[raddr];

endmodule

// File: rtl/fp_adder.sv
// Combinational FP32 adder/subtractor (Mode 0 add, 1 subtract) with the four
// IEEE rounding modes on RMode. Subnormals flush to zero; overflow gives inf.
module FP_Adder (
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        Mode,
  input  logic [1:0]  RMode,
  input  logic        Valid_In,
  output logic [31:0] Result,
  output logic        Valid_Out
);
  import batch_norm_pkg::*;

  logic              sa, sb, sx, sy, swap, zsign;
  logic              a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  logic [7:0]        ex, ey, d;
  logic [4:0]        d_c, lz;
  logic [26:0]       mx, my, ay, norm;
  logic [53:0]       ext;
  logic [27:0]       sum;
  logic signed [9:0] exp_n;
  logic              found, up, g, rest;
  logic [23:0]       mant_r;

  assign Valid_Out = Valid_In;

  // Align the smaller operand, add or subtract magnitudes, renormalise, round.
  always_comb begin
    Result = FP_ZERO;
    sa     = A[31];
    sb     = B[31] ^ Mode;
    a_zero = (A[30:23] == 8'h00);
    b_zero = (B[30:23] == 8'h00);
    a_inf  = (A[30:23] == 8'hFF) && (A[22:0] == 23'd0);
    b_inf  = (B[30:23] == 8'hFF) && (B[22:0] == 23'd0);
    a_nan  = (A[30:23] == 8'hFF) && (A[22:0] != 23'd0);
    b_nan  = (B[30:23] == 8'hFF) && (B[22:0] != 23'd0);
    // Exact cancellation gives -0 only when rounding toward -inf.
    zsign  = (RMode == 2'b11) ? (sa | sb) : (sa & sb);

    swap = (B[30:0] > A[30:0]);
    sx   = swap ? sb : sa;
    sy   = swap ? sa : sb;
    ex   = swap ? B[30:23] : A[30:23];
    ey   = swap ? A[30:23] : B[30:23];
    mx   = swap ? {1'b1, B[22:0], 3'b000} : {1'b1, A[22:0], 3'b000};
    my   = swap ? {1'b1, A[22:0], 3'b000} : {1'b1, B[22:0], 3'b000};
    d    = ex - ey;
    d_c  = (d > 8'd27) ? 5'd27 : d[4:0];
    ext  = {my, 27'd0} >> d_c;
    ay   = ext[53:27] | {26'd0, |ext[26:0]};
    sum  = (sx == sy) ? ({1'b0, mx} + {1'b0, ay}) : ({1'b0, mx} - {1'b0, ay});

    exp_n = signed'({2'b00, ex});
    lz    = 5'd0;
    found = 1'b0;
    if (sum[27]) begin
      norm  = sum[27:1] | {26'd0, sum[0]};
      exp_n = exp_n + 10'sd1;
    end else begin
      for (int i = 26; i >= 0; i--) begin
        if (!found && sum[i]) begin
          lz    = 5'(26 - i);
          found = 1'b1;
        end
      end
      norm  = sum[26:0] << lz;
      exp_n = exp_n - signed'({5'd0, lz});
    end

    g    = norm[2];
    rest = norm[1] | norm[0];
    case (RMode)
      2'b00:   up = g & (rest | norm[3]);
      2'b01:   up = 1'b0;
      2'b10:   up = (g | rest) & ~sx;
      default: up = (g | rest) & sx;
    endcase
    mant_r = {1'b0, norm[25:3]} + 24'(up);
    if (mant_r[23]) exp_n = exp_n + 10'sd1;

    if (a_nan || b_nan || (a_inf && b_inf && (sa != sb))) Result = FP_QNAN;
    else if (a_inf)             Result = {sa, 8'hFF, 23'd0};
    else if (b_inf)             Result = {sb, 8'hFF, 23'd0};
    else if (a_zero && b_zero)  Result = {zsign, 31'd0};
    else if (a_zero)            Result = {sb, B[30:0]};
    else if (b_zero)            Result = A;
    else if (!norm[26])         Result = {zsign, 31'd0};
    else if (exp_n >= 10'sd255) Result = {sx, 8'hFF, 23'd0};
    else if (exp_n <= 10'sd0)   Result = {sx, 31'd0};
    else                        Result = {sx, exp_n[7:0], mant_r[22:0]};
  end

endmodule

// File: rtl/fp_mul.sv
// Combinational FP32 multiplier, round-to-nearest-even. Subnormal inputs are
// treated as zero and underflowing results flush to signed zero.
module FP_Mul (
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        Valid_In,
  output logic [31:0] Result,
  output logic        Valid_Out
);
  import batch_norm_pkg::*;

  logic              sign;
  logic              a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  logic [47:0]       prod;
  logic signed [9:0] exp_s;
  logic [22:0]       mant;
  logic              guard, sticky, round_up;
  logic [23:0]       mant_r;

  assign Valid_Out = Valid_In;

  // Classify operands, multiply significands, normalise and round.
  always_comb begin
    // NOTE: combinational blocks use blocking '=' so later lines see the
    // values computed above them within the same evaluation.
    // NOTE: every output of this block gets a value before any branch, so no
    // path can leave a signal unassigned and infer a latch.
    Result = FP_ZERO;
    sign   = A[31] ^ B[31];
    a_zero = (A[30:23] == 8'h00);
    b_zero = (B[30:23] == 8'h00);
    a_inf  = (A[30:23] == 8'hFF) && (A[22:0] == 23'd0);
    b_inf  = (B[30:23] == 8'hFF) && (B[22:0] == 23'd0);
    a_nan  = (A[30:23] == 8'hFF) && (A[22:0] != 23'd0);
    b_nan  = (B[30:23] == 8'hFF) && (B[22:0] != 23'd0);
    prod   = 48'({1'b1, A[22:0]}) * 48'({1'b1, B[22:0]});
    exp_s  = signed'({2'b00, A[30:23]}) + signed'({2'b00, B[30:23]}) - 10'sd127;
    if (prod[47]) begin
      mant   = prod[46:24];
      guard  = prod[23];
      sticky = |prod[22:0];
      exp_s  = exp_s + 10'sd1;
    end else begin
      mant   = prod[45:23];
      guard  = prod[22];
      sticky = |prod[21:0];
    end
    round_up = guard & (sticky | mant[0]);
    mant_r   = {1'b0, mant} + 24'(round_up);
    if (mant_r[23]) exp_s = exp_s + 10'sd1;

    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) Result = FP_QNAN;
    else if (a_inf || b_inf)    Result = {sign, 8'hFF, 23'd0};
    else if (a_zero || b_zero)  Result = {sign, 31'd0};
    else if (exp_s >= 10'sd255) Result = {sign, 8'hFF, 23'd0};
    else if (exp_s <= 10'sd0)   Result = {sign, 31'd0};
    else                        Result = {sign, exp_s[7:0], mant_r[22:0]};
  end

endmodule

// File: rtl/batch_norm_pipe.sv
// Two-stage FP32 batch-norm pipeline y = A[c]*x + B[c] with auto-advancing
// channel counter, optional fused ReLU and valid/ready flow control.
module batch_norm_pipe
  import batch_norm_pkg::*;
#(
  parameter int  NUM_CH = 16,
  parameter int  DATA_W = 32,
  localparam int CH_W   = $clog2(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        mode,
  input  logic              coef_we,
  input  logic [CH_W-1:0]   coef_addr,
  input  logic [31:0]       coef_a,
  input  logic [31:0]       coef_b,
  input  logic              ch_clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CH_W-1:0]   out_ch,
  output logic              out_last
);

  if (DATA_W != 32) begin : g_bad_data_w
    $error("batch_norm_pipe: DATA_W must be 32 (FP32 only)");
  end
  if (NUM_CH < 2) begin : g_bad_num_ch
    $error("batch_norm_pipe: NUM_CH must be at least 2");
  end

  logic              en1, en2, accept;
  logic [CH_W-1:0]   ch_cnt_q, ch_cnt_d;
  logic              s1_valid_q, s1_valid_d;
  s1_payload_t       s1_q, s1_d;
  logic [CH_W-1:0]   s1_ch_q, s1_ch_d;
  logic              s2_valid_q, s2_valid_d;
  logic [31:0]       out_data_q, out_data_d;
  logic [CH_W-1:0]   out_ch_q, out_ch_d;
  logic              out_last_q, out_last_d;
  logic [31:0]       tbl_a, tbl_b, prod, bn_sum, result;
  logic              mul_valid_unused, add_valid_unused;

  // Each stage advances when it is empty or its successor is advancing.
  always_comb begin
    en2    = ~s2_valid_q | out_ready;
    en1    = ~s1_valid_q | en2;
    accept = in_valid & en1;
  end

  bn_coef_table #(.NUM_CH(NUM_CH), .CH_W(CH_W)) u_coef (
    .clk     (clk),
    .rst     (rst),
    .we      (coef_we),
    .waddr   (coef_addr),
    .wdata_a (coef_a),
    .wdata_b (coef_b),
    .raddr   (ch_cnt_q),
    .rdata_a (tbl_a),
    .rdata_b (tbl_b)
  );

  FP_Mul u_mul (
    .A         (tbl_a),
    .B         (in_data),
    .Valid_In  (accept),
    .Result    (prod),
    .Valid_Out (mul_valid_unused)
  );

  FP_Adder u_add (
    .A         (s1_q.prod),
    .B         (s1_q.shift),
    .Mode      (1'b0),
    .RMode     (2'b00),
    .Valid_In  (s1_valid_q),
    .Result    (bn_sum),
    .Valid_Out (add_valid_unused)
  );

  // Stage-2 result select; ReLU zeroes anything with the sign bit set.
  always_comb begin
    result = bn_sum;
    case (s1_q.mode)
      MODE_BYPASS:  result = s1_q.raw;
      MODE_BN_RELU: result = bn_sum[31] ? FP_ZERO : bn_sum;
      default:      result = bn_sum;
    endcase
  end

  // Next-state for the channel counter and both pipeline stages.
  always_comb begin
    ch_cnt_d = ch_cnt_q;
    if (ch_clr)      ch_cnt_d = '0;
    else if (accept) ch_cnt_d = (int'(ch_cnt_q) == NUM_CH - 1) ? '0 : ch_cnt_q + CH_W'(1);

    s1_valid_d = s1_valid_q;
    s1_d       = s1_q;
    s1_ch_d    = s1_ch_q;
    if (en1) begin
      s1_valid_d = accept;
      if (accept) begin
        s1_d.prod  = prod;
        s1_d.shift = tbl_b;
        s1_d.raw   = in_data;
        s1_d.mode  = decode_mode(mode);
        s1_ch_d    = ch_cnt_q;
      end
    end

    s2_valid_d = s2_valid_q;
    out_data_d = out_data_q;
    out_ch_d   = out_ch_q;
    out_last_d = out_last_q;
    if (en2) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_data_d = result;
        out_ch_d   = s1_ch_q;
        out_last_d = (int'(s1_ch_q) == NUM_CH - 1);
      end
    end
  end

  // Pipeline and counter registers; reset drops everything in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      ch_cnt_q   <= '0;
      s1_valid_q <= 1'b0;
      s1_q       <= '0;
      s1_ch_q    <= '0;
      s2_valid_q <= 1'b0;
      out_data_q <= FP_ZERO;
      out_ch_q   <= '0;
      out_last_q <= 1'b0;
    end else begin
      ch_cnt_q   <= ch_cnt_d;
      s1_valid_q <= s1_valid_d;
      s1_q       <= s1_d;
      s1_ch_q    <= s1_ch_d;
      s2_valid_q <= s2_valid_d;
      out_data_q <= out_data_d;
      out_ch_q   <= out_ch_d;
      out_last_q <= out_last_d;
    end
  end

  assign in_ready  = en1;
  assign out_valid = s2_valid_q;
  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;
  assign out_last  = out_last_q;

endmodule

// File: tb/tb_batch_norm_pipe.sv
// Directed bench for batch_norm_pipe with a 4-entry coefficient table.
module tb_batch_norm_pipe;
  import batch_norm_pkg::*;

  localparam int NUM_CH = 4;
  localparam int CH_W   = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [1:0]      mode;
  logic            coef_we;
  logic [CH_W-1:0] coef_addr;
  logic [31:0]     coef_a, coef_b;
  logic            ch_clr;
  logic            in_valid, in_ready;
  logic [31:0]     in_data;
  logic            out_valid, out_ready;
  logic [31:0]     out_data;
  logic [CH_W-1:0] out_ch;
  logic            out_last;

  int checks   = 0;
  int failures = 0;

  logic [31:0]     mon_data[$];
  logic [CH_W-1:0] mon_ch[$];
  logic            mon_last[$];

  batch_norm_pipe #(.NUM_CH(NUM_CH), .DATA_W(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode),
    .coef_we   (coef_we),
    .coef_addr (coef_addr),
    .coef_a    (coef_a),
    .coef_b    (coef_b),
    .ch_clr    (ch_clr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  // Record every completed output handshake (inputs are stable at negedge).
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      mon_data.push_back(out_data);
      mon_ch.push_back(out_ch);
      mon_last.push_back(out_last);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_ch();
    ch_clr = 1'b1;
    tick();
    ch_clr = 1'b0;
  endtask

  task automatic write_coef(input logic [CH_W-1:0] ch, input logic [31:0] a, input logic [31:0] b);
    coef_we = 1'b1; coef_addr = ch; coef_a = a; coef_b = b;
    tick();
    coef_we = 1'b0;
  endtask

  task automatic flush_mon();
    mon_data.delete(); mon_ch.delete(); mon_last.delete();
  endtask

  task automatic wait_mon(input string tag, input int n);
    for (int k = 0; k < 60 && mon_data.size() < n; k++) tick();
    check(tag, 32'(mon_data.size()), 32'(n));
  endtask

  // One isolated sample: checks acceptance, 2-cycle latency and the result.
  task automatic txn(input string tag, input logic [31:0] x, input logic [1:0] m,
                     input logic [31:0] exp, input logic [CH_W-1:0] exp_ch);
    in_valid = 1'b1; in_data = x; mode = m;
    #1 check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0; coef_we = 1'b0;
    check({tag, "_lat1_valid"}, 32'(out_valid), 32'd0);
    tick();
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_data"}, out_data, exp);
    check({tag, "_ch"}, 32'(out_ch), 32'(exp_ch));
    check({tag, "_last"}, 32'(out_last), 32'(exp_ch == 2'd3));
    tick();
  endtask

  int exp_ch_a[10] = '{0, 1, 2, 3, 0, 1, 2, 3, 0, 1};
  int exp_ch_b[8]  = '{0, 1, 2, 3, 0, 1, 0, 1};
  int exp_ch_c[8]  = '{0, 1, 2, 3, 0, 1, 2, 3};

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; mode = 2'b01; coef_we = 1'b0; coef_addr = '0; coef_a = '0; coef_b = '0;
    ch_clr = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    repeat (3) tick();
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", out_data, 32'h0);
    check("rst_out_ch", 32'(out_ch), 32'd0);
    check("rst_out_last", 32'(out_last), 32'd0);
    rst = 1'b0;
    #1 check("rst_in_ready", 32'(in_ready), 32'd1);
    tick();

    // Identity table after reset.
    txn("ident", 32'h4040_0000, 2'b01, 32'h4040_0000, 2'd0);

    // Coefficient write on ch3, with a ch3 sample in the write cycle itself.
    clr_ch();
    txn("pre_c0", 32'h4040_0000, 2'b01, 32'h4040_0000, 2'd0);
    txn("pre_c1", 32'h4040_0000, 2'b01, 32'h4040_0000, 2'd1);
    txn("pre_c2", 32'h4040_0000, 2'b01, 32'h4040_0000, 2'd2);
    coef_we = 1'b1; coef_addr = 2'd3; coef_a = 32'h4000_0000; coef_b = 32'h3F80_0000;
    txn("wr_same_cycle", 32'h4040_0000, 2'b01, 32'h4040_0000, 2'd3);
    txn("post_c0", 32'h4040_0000, 2'b01, 32'h4040_0000, 2'd0);
    txn("post_c1", 32'h4040_0000, 2'b01, 32'h4040_0000, 2'd1);
    txn("post_c2", 32'h4040_0000, 2'b01, 32'h4040_0000, 2'd2);
    txn("bn_c3", 32'h4040_0000, 2'b01, 32'h40E0_0000, 2'd3);

    // ReLU and bypass on ch0 with A=-1.0, B=0.
    write_coef(2'd0, 32'hBF80_0000, 32'h0000_0000);
    txn("relu_pos", 32'h4000_0000, 2'b10, 32'h0000_0000, 2'd0);
    clr_ch();
    txn("relu_neg", 32'hC000_0000, 2'b10, 32'h4000_0000, 2'd0);
    clr_ch();
    txn("bypass", 32'hC000_0000, 2'b00, 32'hC000_0000, 2'd0);
    clr_ch();
    txn("mode11_bn", 32'h4000_0000, 2'b11, 32'hC000_0000, 2'd0);

    // Ten back-to-back samples: channel wrap and out_last.
    clr_ch();
    flush_mon();
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; in_data = 32'h4100_0000 + 32'(i); mode = 2'b00;
      tick();
    end
    in_valid = 1'b0;
    wait_mon("strm_count", 10);
    for (int i = 0; i < 10 && i < mon_data.size(); i++) begin
      check($sformatf("strm_data%0d", i), mon_data[i], 32'h4100_0000 + 32'(i));
      check($sformatf("strm_ch%0d", i), 32'(mon_ch[i]), 32'(exp_ch_a[i]));
      check($sformatf("strm_last%0d", i), 32'(mon_last[i]), 32'(exp_ch_a[i] == 3));
    end

    // ch_clr together with the 6th accept.
    clr_ch();
    flush_mon();
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_data = 32'h4110_0000 + 32'(i); ch_clr = (i == 5);
      tick();
    end
    in_valid = 1'b0; ch_clr = 1'b0;
    wait_mon("clr_count", 8);
    for (int i = 0; i < 8 && i < mon_ch.size(); i++)
      check($sformatf("clr_ch%0d", i), 32'(mon_ch[i]), 32'(exp_ch_b[i]));

    // Backpressure: out_ready low for 5 cycles during a continuous stream.
    clr_ch();
    flush_mon();
    begin
      int sent;
      logic acc;
      sent = 0;
      for (int c = 0; c < 40 && sent < 8; c++) begin
        out_ready = !(c >= 3 && c < 8);
        in_valid  = 1'b1;
        in_data   = 32'h4200_0000 + 32'(sent);
        #1;
        acc = in_ready;
        if (c >= 3 && c < 8) begin
          check($sformatf("bp_in_ready_c%0d", c), 32'(in_ready), 32'd0);
          check($sformatf("bp_valid_c%0d", c), 32'(out_valid), 32'd1);
          check($sformatf("bp_hold_data_c%0d", c), out_data, 32'h4200_0001);
          check($sformatf("bp_hold_ch_c%0d", c), 32'(out_ch), 32'd1);
        end
        @(posedge clk); #1;
        if (acc) sent++;
      end
      check("bp_sent", 32'(sent), 32'd8);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    wait_mon("bp_count", 8);
    for (int i = 0; i < 8 && i < mon_data.size(); i++) begin
      check($sformatf("bp_data%0d", i), mon_data[i], 32'h4200_0000 + 32'(i));
      check($sformatf("bp_ch%0d", i), 32'(mon_ch[i]), 32'(exp_ch_c[i]));
    end

    // Reset with two samples in flight (held by backpressure).
    flush_mon();
    out_ready = 1'b0; mode = 2'b01;
    in_valid = 1'b1; in_data = 32'h40A0_0000; tick();
    in_data = 32'h40C0_0000; tick();
    in_valid = 1'b0;
    check("rst_mid_pre_valid", 32'(out_valid), 32'd1);
    rst = 1'b1;
    tick();
    check("rst_mid_valid", 32'(out_valid), 32'd0);
    rst = 1'b0; out_ready = 1'b1;
    repeat (5) tick();
    check("rst_mid_no_stale", 32'(mon_data.size()), 32'd0);
    txn("rst_identity", 32'h40A0_0000, 2'b01, 32'h40A0_0000, 2'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/batch_norm_pipe.md
# batch_norm_pipe

Parametrised, pipelined successor to the single-channel FP32 batch-normalisation datapath. Computes y = A[c]·x + B[c] in IEEE-754 single precision for a stream of activations. Per-channel coefficients A, B sit in an internal table; the channel index advances automatically per accepted sample. The block adds a valid/ready handshake with backpressure, a fixed 2-cycle latency and an optional fused ReLU, and sits between a convolution accumulator and the next layer's input buffer.

## Interface
- NUM_CH, 16: channels per coefficient table (≥2); CH_W = $clog2(NUM_CH).
- DATA_W, 32: data width; only 32 (FP32) is legal, elaborate-time error otherwise.
- clk  in  1  clock; one clock; all logic on rising edge.
- rst  in  1  reset, synchronous and active-high.
- mode  in  2  00 bypass (y=x), 01 BN, 10 BN+ReLU, 11 treated as 01; sampled per accepted sample.
- coef_we  in  1  write coefficient pair.
- coef_addr  in  CH_W  channel to write; addr ≥ NUM_CH ignored.
- coef_a, coef_b  in  32  scale and shift written at coef_addr.
- ch_clr  in  1  forces channel counter to 0.
- in_valid / in_ready  in / out  1  input handshake.
- in_data  in  32  activation x.
- out_valid / out_ready  out / in  1  output handshake.
- out_data  out  32  result y.
- out_ch  out  CH_W  channel of out_data.
- out_last  out  1  out_ch == NUM_CH-1.

## Operation
- Accept when in_valid & in_ready. The sample takes channel ch_cnt; ch_cnt then increments and wraps NUM_CH-1 → 0.
- ch_clr sets ch_cnt=0 next cycle. ch_clr with a simultaneous accept: the sample uses the current ch_cnt, and next ch_cnt=0 (clear wins over increment).
- Coefficient table: NUM_CH×64-bit registers, reset to A=0x3F800000 (1.0), B=0x00000000, so reset state is identity.
- Writes land at the clock edge. A sample accepted in the same cycle as a write to its channel reads the old value.
- Stage 1 (S1): register FP_Mul(A[c], x), B[c], raw x, mode, c.
- Stage 2 (S2): register result.
  - bypass → raw x.
  - BN → FP_Adder(product, B), mode add, RMode 00 (round-nearest-even).
  - BN+ReLU → BN result, or 0x00000000 if its sign bit is 1. This includes -0.0 and negative NaN.
- NaN/Inf behaviour is inherited from FP_Mul/FP_Adder unchanged.

## Timing
- Reset values: in_ready=1 when rst deasserted, out_valid=0, out_data=0, out_ch=0, out_last=0, ch_cnt=0, pipeline valids=0, coefficients as above.
- Latency is exactly 2 cycles from accept to out_valid with no backpressure. Throughput is 1 sample/cycle.
- Pipeline advance: en2 = ~s2_valid | out_ready; en1 = ~s1_valid | en2; in_ready = en1. in_ready is combinational from out_ready and internal valids, never from in_valid.
- Stall: while out_valid & ~out_ready, out_data/out_ch/out_last stay stable and no sample is lost or duplicated. At most 2 samples are buffered.
- rst mid-stream: all in-flight samples are dropped, out_valid=0 the next cycle, and the coefficient table returns to identity.

## Structure
- Package batch_norm_pkg holds:
  - mode constants MODE_BYPASS, MODE_BN, MODE_BN_RELU;
  - FP32 constants FP_ONE, FP_ZERO;
  - a packed struct for the S1 payload.
- Sub-module bn_coef_table holds the register file: one write port, combinational read at ch_cnt, synchronous-reset identity init.
- FP_Mul and FP_Adder are instantiated unchanged, each with its Valid_Out left unused.

## Test plan
- Identity after reset, mode=01, in_data=0x40400000 (3.0) on channel 0 → out_data=0x40400000 at cycle+2, out_ch=0.
- Write ch3 A=0x40000000 (2.0), B=0x3F800000 (1.0); send 3.0 to channel 3 → 0x40E00000 (7.0), out_ch=3. A sample to ch3 in the write cycle itself → 3.0 (old coefficients).
- ReLU: ch0 A=0xBF800000 (-1.0), B=0; mode=10, x=2.0 → 0x00000000. x=-2.0 → 0x40000000. mode=00, x=-2.0 → 0xC0000000.
- Streaming with NUM_CH=4: 10 back-to-back samples → out_ch sequence 0,1,2,3,0,1,2,3,0,1 and out_last high on each 3.
  - ch_clr pulsed together with the 6th accept → that sample is ch1 and the 7th is ch0.
- Backpressure: out_ready held low 5 cycles during a continuous stream → in_ready drops after 2 buffered samples, out_data stable throughout, full ordered sequence out afterwards with no loss.
- rst asserted with 2 samples in flight → out_valid=0 next cycle, no stale output after release, table back to identity (x=5.0 → 5.0).
